alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Issue stage that drives the RV32I integer ALU (4-bit funct: funct[3] = SUB/SRA select, funct[2:0] = RISC-V funct3).
- Accepts a fetched instruction plus its pc and register-file read values over a valid/ready handshake.
- Decodes OP, OP-IMM, LUI and AUIPC into ALU operands, funct and writeback info.
- Presents the result through a registered, 2-entry skid-buffered valid/ready output.

Parameters:
- XLEN, 32, operand/pc width.
- SKID_EN, 1, 1 = 2-entry skid buffer (full throughput); 0 = single register (in_ready = !out_valid || out_ready).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all buffered entries
- in_valid  in  1  input beat valid
- in_ready  out  1  stage can accept a beat
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- in_rs1_val  in  XLEN  rs1 read value
- in_rs2_val  in  XLEN  rs2 read value
- out_valid  out  1  ALU request valid
- out_ready  in  1  ALU/execute consumer accepts
- out_src1  out  XLEN  ALU src1
- out_src2  out  XLEN  ALU src2
- out_funct  out  4  ALU funct
- out_rd  out  5  destination register
- out_we  out  1  register writeback enable
- out_illegal  out  1  instruction not supported by this stage

Behaviour:
- Reset (async assert, sync release): out_valid=0, in_ready=1, all out data=0, skid empty.
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Latency is one cycle: a beat accepted at edge N is visible on out_* after edge N.
- Skid buffer:
  - Main register drives out_*.
  - When main is valid and not taken and a beat is accepted, the beat goes to skid.
  - in_ready is registered and equals !skid_valid.
  - On output transfer with skid valid, skid moves to main.
  - Order is strictly preserved; sustained throughput is 1 beat/cycle; no beat is lost or duplicated.
  - Output data is stable while out_valid && !out_ready.
- Decode (combinational, then registered):
  - OP (0110011): src1=rs1_val, src2=rs2_val, funct={funct7[5],funct3}.
    - funct7 must be 0000000, or 0100000 only with funct3 000/101; anything else is illegal.
  - OP-IMM (0010011): src1=rs1_val, src2=sign-extended imm[11:0], funct={0,funct3}.
    - Exception: funct3=101 with imm[11:5]=0100000 gives funct=1101 (SRAI).
    - Shifts (funct3 001/101) with any other imm[11:5] value are illegal, except 0000000 (and 0100000 for 101).
    - ADDI never sets funct[3], whatever the imm bits.
  - LUI (0110111): src1=0, src2={instr[31:12],12'b0}, funct=0000.
  - AUIPC (0010111): src1=pc, src2={instr[31:12],12'b0}, funct=0000.
  - Any other opcode: illegal.
- out_we = legal && rd!=0.
- Illegal beats still issue: out_illegal=1, out_we=0, src1/src2/funct=0, rd from the instruction.
- flush:
  - At the next edge, main and skid are invalidated and in_ready=1.
  - A beat presented in the flush cycle is dropped even if in_valid && in_ready.
  - Flush has priority over all other events.
- Reset asserted mid-operation clears everything immediately; no partial beat survives.
- Simultaneous input and output transfer with the skid empty: main is replaced by the new beat in the same edge.

Decomposition:
- Package alu_pkg:
  - Opcode constants: OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC.
  - ALU funct constants: ALU_ADD=0000, ALU_SUB=1000, ALU_SLL=0001, ALU_SLT=0010, ALU_SLTU=0011, ALU_XOR=0100, ALU_SRL=0101, ALU_SRA=1101, ALU_OR=0110, ALU_AND=0111.
  - Typedef alu_req_t struct {src1, src2, funct, rd, we, illegal}.
- Sub-module alu_decode: purely combinational instr/pc/rs values -> alu_req_t, instantiated once.
- The top holds the handshake and the skid buffer only.

Test Plan:
- ADD 0x002081B3, rs1=5, rs2=7 -> next cycle out_valid=1, src1=5, src2=7, funct=0000, rd=3, we=1. SUB 0x402081B3 -> funct=1000.
- SRAI 0x40435293, rs1=0x80000000 -> src2[4:0]=4, funct=1101, rd=5. ADDI 0xFFF00093 -> src2=0xFFFFFFFF, funct=0000, rd=1, we=1.
- LUI 0x123450B7 -> src1=0, src2=0x12345000. AUIPC 0x12345097 with pc=0x1000 -> src1=0x1000, src2=0x12345000, funct=0000.
- Backpressure: 3 back-to-back beats with out_ready=0 for 3 cycles.
  - in_ready=0 after the 2nd acceptance; 3rd is held at the input.
  - After out_ready=1, outputs appear in order 1,2,3; out_* is stable while stalled.
- Illegal beats:
  - MUL 0x022081B3 -> out_illegal=1, we=0, funct=0000.
  - LW 0x00002083 -> out_illegal=1.
  - ADD with rd=0 (0x00208033) -> legal, we=0.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, the flush-cycle beat never appears.
- Repeat the same full-buffer condition with rst_n pulsed low mid-cycle -> out_valid=0 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the RV32I ALU issue stage: major
//               opcodes, ALU funct encodings, the issued request record and
//               immediate-extraction helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

  // Width of the request datapath. The issue stage XLEN parameter must not
  // exceed this value.
  localparam int ALU_XLEN = 32;

  // RV32I major opcodes (instr[6:0]) handled by the issue stage
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // ALU funct: bit 3 selects SUB/SRA, bits 2:0 are the RISC-V funct3
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  // funct7 values that are legal alongside the base integer operations
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // funct3 values with special legality rules
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  // One issued ALU request
  typedef struct packed {
    logic [ALU_XLEN-1:0] src1;
    logic [ALU_XLEN-1:0] src2;
    logic [3:0]          funct;
    logic [4:0]          rd;
    logic                we;
    logic                illegal;
  } alu_req_t;

  // I-type immediate, sign-extended
  function automatic logic [ALU_XLEN-1:0] imm_i(input logic [31:0] instr);
    return {{(ALU_XLEN-12){instr[31]}}, instr[31:20]};
  endfunction

  // U-type immediate, upper 20 bits with low 12 bits cleared
  function automatic logic [ALU_XLEN-1:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// ============================================================================
// Module      : alu_decode
// Description : Purely combinational decode of OP, OP-IMM, LUI and AUIPC
//               into an ALU request (operands, funct, rd, write enable,
//               illegal flag).
// Ports       : instr    - 32-bit instruction word
//               pc       - instruction address
//               rs1_val  - rs1 register-file value
//               rs2_val  - rs2 register-file value
//               req      - decoded ALU request
// Revision    : 1.0 - initial release
// ============================================================================
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]       instr,
  input  logic [ALU_XLEN-1:0] pc,
  input  logic [ALU_XLEN-1:0] rs1_val,
  input  logic [ALU_XLEN-1:0] rs2_val,
  output alu_req_t          req
);

  logic [6:0]          w_opcode;
  logic [4:0]          w_rd;
  logic [2:0]          w_funct3;
  logic [6:0]          w_funct7;
  logic                w_legal;
  logic [ALU_XLEN-1:0] w_src1;
  logic [ALU_XLEN-1:0] w_src2;
  logic [3:0]          w_funct;

  assign w_opcode = instr[6:0];
  assign w_rd     = instr[11:7];
  assign w_funct3 = instr[14:12];
  assign w_funct7 = instr[31:25];

  always_comb begin
    w_legal = 1'b0;
    w_src1  = '0;
    w_src2  = '0;
    w_funct = ALU_ADD;

    case (w_opcode)
      OPC_OP: begin
        w_src1  = rs1_val;
        w_src2  = rs2_val;
        w_funct = {w_funct7[5], w_funct3};
        // The alternate funct7 only exists for SUB and SRA; M-extension
        // and other funct7 values are not handled here.
        if (w_funct7 == F7_BASE) begin
          w_legal = 1'b1;
        end else if (w_funct7 == F7_ALT &&
                     (w_funct3 == F3_ADD_SUB || w_funct3 == F3_SRL_SRA)) begin
          w_legal = 1'b1;
        end
      end

      OPC_OP_IMM: begin
        w_src1  = rs1_val;
        w_src2  = imm_i(instr);
        w_funct = {1'b0, w_funct3};
        // Only shifts carry an encoding in imm[11:5]; every other OP-IMM
        // (notably ADDI) takes the full 12-bit immediate and never sets
        // funct[3].
        if (w_funct3 == F3_SLL) begin
          w_legal = (w_funct7 == F7_BASE);
        end else if (w_funct3 == F3_SRL_SRA) begin
          if (w_funct7 == F7_BASE) begin
            w_legal = 1'b1;
          end else if (w_funct7 == F7_ALT) begin
            w_legal = 1'b1;
            w_funct = ALU_SRA;
          end
        end else begin
          w_legal = 1'b1;
        end
      end

      OPC_LUI: begin
        w_legal = 1'b1;
        w_src1  = '0;
        w_src2  = imm_u(instr);
        w_funct = ALU_ADD;
      end

      OPC_AUIPC: begin
        w_legal = 1'b1;
        w_src1  = pc;
        w_src2  = imm_u(instr);
        w_funct = ALU_ADD;
      end

      default: begin
        w_legal = 1'b0;
      end
    endcase
  end

  // Illegal beats still issue so the exception can be raised downstream,
  // but carry no operands and never write the register file.
  always_comb begin
    req         = '0;
    req.rd      = w_rd;
    req.illegal = !w_legal;
    req.we      = w_legal && (w_rd != 5'd0);
    if (w_legal) begin
      req.src1  = w_src1;
      req.src2  = w_src2;
      req.funct = w_funct;
    end
  end

endmodule : alu_decode
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue
// Description : Issue stage for the RV32I integer ALU. Accepts instruction,
//               pc and register values over valid/ready, decodes them and
//               presents the ALU request from a registered output, optionally
//               backed by a skid entry for full throughput.
// Ports       : clk, rst_n       - clock / async active-low reset
//               flush            - synchronous kill of all buffered beats
//               in_valid/in_ready- input handshake
//               in_instr, in_pc, in_rs1_val, in_rs2_val - input payload
//               out_valid/out_ready - output handshake
//               out_src1, out_src2, out_funct, out_rd, out_we, out_illegal
//                                - decoded ALU request
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit SKID_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_src1,
  output logic [XLEN-1:0] out_src2,
  output logic [3:0]      out_funct,
  output logic [4:0]      out_rd,
  output logic            out_we,
  output logic            out_illegal
);

  alu_req_t w_dec;
  logic     w_in_xfer;
  logic     w_out_xfer;

  // Main output register; written by whichever buffering variant is built
  logic     r_main_valid;
  alu_req_t r_main;

  alu_decode u_decode (
    .instr   (in_instr),
    .pc      (ALU_XLEN'(in_pc)),
    .rs1_val (ALU_XLEN'(in_rs1_val)),
    .rs2_val (ALU_XLEN'(in_rs2_val)),
    .req     (w_dec)
  );

  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = r_main_valid && out_ready;

  generate
    if (SKID_EN) begin : g_skid
      logic     r_skid_valid;
      alu_req_t r_skid;
      logic     r_in_ready;

      // in_ready is a flop that tracks !r_skid_valid, so the upstream
      // ready path never sees out_ready combinationally.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_main_valid <= 1'b0;
          r_main       <= '0;
          r_skid_valid <= 1'b0;
          r_skid       <= '0;
          r_in_ready   <= 1'b1;
        end else if (flush) begin
          r_main_valid <= 1'b0;
          r_skid_valid <= 1'b0;
          r_in_ready   <= 1'b1;
        end else if (!r_main_valid || w_out_xfer) begin
          // Main is free this edge. A held skid beat is older than anything
          // at the input (and the input is blocked while skid is full).
          if (r_skid_valid) begin
            r_main       <= r_skid;
            r_main_valid <= 1'b1;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b1;
          end else if (w_in_xfer) begin
            r_main       <= w_dec;
            r_main_valid <= 1'b1;
          end else begin
            r_main_valid <= 1'b0;
          end
        end else if (w_in_xfer) begin
          // Main stalled: park the accepted beat in the skid entry
          r_skid       <= w_dec;
          r_skid_valid <= 1'b1;
          r_in_ready   <= 1'b0;
        end
      end

      assign in_ready = r_in_ready;
    end else begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_main_valid <= 1'b0;
          r_main       <= '0;
        end else if (flush) begin
          r_main_valid <= 1'b0;
        end else if (w_in_xfer) begin
          r_main       <= w_dec;
          r_main_valid <= 1'b1;
        end else if (w_out_xfer) begin
          r_main_valid <= 1'b0;
        end
      end

      assign in_ready = !r_main_valid || out_ready;
    end
  endgenerate

  assign out_valid   = r_main_valid;
  assign out_src1    = r_main.src1[XLEN-1:0];
  assign out_src2    = r_main.src2[XLEN-1:0];
  assign out_funct   = r_main.funct;
  assign out_rd      = r_main.rd;
  assign out_we      = r_main.we;
  assign out_illegal = r_main.illegal;

endmodule : alu_issue
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue
// Description : Self-checking bench for alu_issue: table of decode vectors
//               streamed through a scoreboard, plus hand-written sequences
//               for backpressure, flush and mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

  typedef struct packed {
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  funct;
    logic [4:0]  rd;
    logic        we;
    logic        ill;
  } exp_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    exp_t        e;
  } vec_t;

  localparam int NV = 17;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_src1;
  logic [31:0] out_src2;
  logic [3:0]  out_funct;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_illegal;

  vec_t vecs [NV];
  exp_t sb [$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  alu_issue #(.XLEN(32), .SKID_EN(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_rs1_val  (in_rs1_val),
    .in_rs2_val  (in_rs2_val),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_src1    (out_src1),
    .out_src2    (out_src2),
    .out_funct   (out_funct),
    .out_rd      (out_rd),
    .out_we      (out_we),
    .out_illegal (out_illegal)
  );

  function automatic vec_t mk(input logic [31:0] i, p, a, b, s1, s2,
                              input logic [3:0] f, input logic [4:0] rd,
                              input logic we, ill);
    vec_t v;
    v.instr = i; v.pc = p; v.rs1 = a; v.rs2 = b;
    v.e.src1 = s1; v.e.src2 = s2; v.e.funct = f; v.e.rd = rd;
    v.e.we = we; v.e.ill = ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_out(input string tag, input exp_t e);
    chk({tag, ".src1"},    out_src1,           e.src1);
    chk({tag, ".src2"},    out_src2,           e.src2);
    chk({tag, ".funct"},   {28'd0, out_funct}, {28'd0, e.funct});
    chk({tag, ".rd"},      {27'd0, out_rd},    {27'd0, e.rd});
    chk({tag, ".we"},      {31'd0, out_we},    {31'd0, e.we});
    chk({tag, ".illegal"}, {31'd0, out_illegal}, {31'd0, e.ill});
  endtask

  // One clock: drive, observe the output handshake against the scoreboard,
  // record an accepted beat, then advance to 1 time unit after the edge.
  task automatic do_cycle(input bit v, input vec_t x, input bit rdy, output bit acc);
    in_valid   = v;
    in_instr   = x.instr;
    in_pc      = x.pc;
    in_rs1_val = x.rs1;
    in_rs2_val = x.rs2;
    out_ready  = rdy;
    flush      = 1'b0;
    #1;
    acc = v && in_ready;
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_output: out_valid=1 with nothing outstanding, rd=%0d at %0t",
                 out_rd, $time);
      end else if (out_ready) begin
        cmp_out("out", sb.pop_front());
      end else begin
        cmp_out("stall", sb[0]);
      end
    end
    if (acc) sb.push_back(x.e);
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input bit rand_ready, input string tag);
    int idx = 0;
    int cyc = 0;
    bit acc;
    bit rdy;
    while ((idx < NV || sb.size() > 0) && cyc < 400) begin
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      do_cycle(idx < NV, vecs[(idx < NV) ? idx : 0], rdy, acc);
      if (acc) idx++;
      cyc++;
    end
    chk({tag, ".all_accepted"}, idx, NV);
    chk({tag, ".all_drained"}, sb.size(), 0);
    chk({tag, ".idle_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  // Load two beats with the consumer stalled so main and skid are both full
  task automatic fill_both();
    bit acc;
    do_cycle(1'b1, vecs[0], 1'b0, acc);
    chk("fill.acc_a", {31'd0, acc}, 32'd1);
    do_cycle(1'b1, vecs[1], 1'b0, acc);
    chk("fill.acc_b", {31'd0, acc}, 32'd1);
    chk("fill.in_ready", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic check_flushed(input string tag);
    bit acc;
    chk({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, ".in_ready"},  {31'd0, in_ready},  32'd1);
    // The dropped beat must never surface; do_cycle flags any output
    repeat (3) do_cycle(1'b0, vecs[0], 1'b1, acc);
    chk({tag, ".still_idle"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin : main
    bit acc;

    vecs[0]  = mk(32'h002081B3, 32'h0, 32'd5,        32'd7, 32'd5,        32'd7,        4'b0000, 5'd3, 1'b1, 1'b0); // ADD
    vecs[1]  = mk(32'h402081B3, 32'h0, 32'd10,       32'd3, 32'd10,       32'd3,        4'b1000, 5'd3, 1'b1, 1'b0); // SUB
    vecs[2]  = mk(32'h40435293, 32'h0, 32'h80000000, 32'd9, 32'h80000000, 32'h00000404, 4'b1101, 5'd5, 1'b1, 1'b0); // SRAI 4
    vecs[3]  = mk(32'hFFF00093, 32'h0, 32'd9,        32'd1, 32'd9,        32'hFFFFFFFF, 4'b0000, 5'd1, 1'b1, 1'b0); // ADDI -1
    vecs[4]  = mk(32'h123450B7, 32'h0, 32'h0000DEAD, 32'd2, 32'd0,        32'h12345000, 4'b0000, 5'd1, 1'b1, 1'b0); // LUI
    vecs[5]  = mk(32'h12345097, 32'h1000, 32'd4,     32'd2, 32'h00001000, 32'h12345000, 4'b0000, 5'd1, 1'b1, 1'b0); // AUIPC
    vecs[6]  = mk(32'h022081B3, 32'h0, 32'd5,        32'd7, 32'd0,        32'd0,        4'b0000, 5'd3, 1'b0, 1'b1); // MUL
    vecs[7]  = mk(32'h00002083, 32'h0, 32'd5,        32'd7, 32'd0,        32'd0,        4'b0000, 5'd1, 1'b0, 1'b1); // LW
    vecs[8]  = mk(32'h00208033, 32'h0, 32'd1,        32'd2, 32'd1,        32'd2,        4'b0000, 5'd0, 1'b0, 1'b0); // ADD x0
    vecs[9]  = mk(32'h40109093, 32'h0, 32'd1,        32'd2, 32'd0,        32'd0,        4'b0000, 5'd1, 1'b0, 1'b1); // SLLI bad imm
    vecs[10] = mk(32'h40008093, 32'h0, 32'd3,        32'd2, 32'd3,        32'h00000400, 4'b0000, 5'd1, 1'b1, 1'b0); // ADDI 0x400
    vecs[11] = mk(32'h4020D1B3, 32'h0, 32'hF0000000, 32'd4, 32'hF0000000, 32'd4,        4'b1101, 5'd3, 1'b1, 1'b0); // SRA
    vecs[12] = mk(32'h0020B1B3, 32'h0, 32'd6,        32'd8, 32'd6,        32'd8,        4'b0011, 5'd3, 1'b1, 1'b0); // SLTU
    vecs[13] = mk(32'h402091B3, 32'h0, 32'd6,        32'd8, 32'd0,        32'd0,        4'b0000, 5'd3, 1'b0, 1'b1); // alt f7 + SLL
    vecs[14] = mk(32'h0040D293, 32'h0, 32'h80000000, 32'd1, 32'h80000000, 32'd4,        4'b0101, 5'd5, 1'b1, 1'b0); // SRLI 4
    vecs[15] = mk(32'h8000C093, 32'h0, 32'h55,       32'd1, 32'h55,       32'hFFFFF800, 4'b0100, 5'd1, 1'b1, 1'b0); // XORI -2048
    vecs[16] = mk(32'h0FF0F093, 32'h0, 32'h1234,     32'd1, 32'h1234,     32'h000000FF, 4'b0111, 5'd1, 1'b1, 1'b0); // ANDI 0xFF

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_rs1_val = '0; in_rs2_val = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.in_ready",  {31'd0, in_ready},  32'd1);
    cmp_out("reset", '0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Streaming decode, full-rate consumer then random backpressure
    run_table(1'b0, "stream");
    run_table(1'b1, "random");

    // Backpressure: A, B accepted, C held while the consumer stalls
    fill_both();
    repeat (3) begin
      do_cycle(1'b1, vecs[4], 1'b0, acc);
      chk("bp.c_held", {31'd0, acc}, 32'd0);
    end
    do_cycle(1'b1, vecs[4], 1'b1, acc);       // A leaves, skid B moves up
    chk("bp.c_blocked", {31'd0, acc}, 32'd0);
    do_cycle(1'b1, vecs[4], 1'b1, acc);       // B leaves, C accepted
    chk("bp.c_accepted", {31'd0, acc}, 32'd1);
    do_cycle(1'b0, vecs[4], 1'b1, acc);       // C leaves
    chk("bp.drained", sb.size(), 0);
    chk("bp.idle", {31'd0, out_valid}, 32'd0);

    // Flush with only main full: in_ready=1, so the presented beat is dropped
    do_cycle(1'b1, vecs[0], 1'b0, acc);
    chk("flush1.in_ready_pre", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_instr = vecs[4].instr; in_rs1_val = vecs[4].rs1;
    out_ready = 1'b0; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    check_flushed("flush1");

    // Flush with main and skid both full and a beat waiting
    fill_both();
    in_valid = 1'b1; in_instr = vecs[4].instr; in_rs1_val = vecs[4].rs1;
    out_ready = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    check_flushed("flush2");

    // Asynchronous reset in the middle of a cycle with both entries full
    fill_both();
    in_valid = 1'b1; in_instr = vecs[4].instr; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst.in_ready",  {31'd0, in_ready},  32'd1);
    cmp_out("arst", '0);
    sb.delete();
    #2 rst_n = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("arst.after_valid", {31'd0, out_valid}, 32'd0);
    do_cycle(1'b1, vecs[0], 1'b1, acc);
    chk("arst.accept", {31'd0, acc}, 32'd1);
    chk("arst.latency_valid", {31'd0, out_valid}, 32'd1);
    do_cycle(1'b0, vecs[0], 1'b1, acc);
    chk("arst.drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_alu_issue
`default_nettype wire
